// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// the datapath mux/ALU select values.
package control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control strobes out.
interface multicycle_control_unit_if #(parameter int unsigned CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o, retired
  );
endinterface

// File: rtl/multicycle_control_unit_retire_counter.sv
// Retired-instruction counter: async active-low clear, wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count one per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (en) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing each instruction over 3-5 cycles and driving the
// multicycle datapath control strobes.
module multicycle_control_unit #(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);
  import control_pkg::*;

  state_t           state, state_next;
  logic             rdy;
  logic             retire_en;
  logic [CNT_W-1:0] retired_q;

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic; opcode only matters in DECODE and MEM_ADDR.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:     if (rdy) state_next = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_R:         state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (rdy) state_next = S_MEM_WB;
      S_MEM_WRITE: if (rdy) state_next = S_FETCH;
      S_EXECUTE:   state_next = S_ALU_WB;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  // Only terminal states ever return to FETCH, so that edge marks a retire.
  assign retire_en = (state != S_FETCH) && (state_next == S_FETCH);

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en),
    .count (retired_q)
  );

  assign bus.retired = retired_q;
  assign bus.state_o = state;

  // Output decode of state; everything gated off while rst_n is low.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALU_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.illegal_op    = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = rdy;
          bus.pc_write  = rdy;
        end
        S_DECODE:    bus.alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNCT;
        end
        S_ALU_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALU_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = PCSRC_ALUOUT;
        end
        S_ADDI_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB:   bus.reg_write = 1'b1;
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_JUMP;
        end
        S_TRAP:      bus.illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle datapath control decoder. A Moore FSM sequences each instruction over 3–5 cycles and drives every datapath control strobe: PC, IR, memory, register file, ALU muxes and ALU op class. It supports a memory-ready stall handshake, a sticky illegal-opcode trap and a retired-instruction counter. It sits between the instruction register's opcode field and the shared-memory multicycle datapath.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.
- `MEM_HANDSHAKE`, 1, 1 means honour `mem_ready`; 0 means `mem_ready` is internally forced to 1.
- `clk  input  1  rising-edge clock`
- `rst_n  input  1  asynchronous, active-low reset`
- `opcode  input  6  IR[31:26]; valid from DECODE onward`
- `mem_ready  input  1  memory completes the current access this cycle`
- `pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes`
- `alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2`
- `alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded`
- `pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target`
- `illegal_op  output  1  sticky trap flag`
- `state_o  output  4  current state encoding (debug)`
- `retired  output  CNT_W  instructions completed since reset`

## Operation
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000, J = 000010. All other opcodes are illegal.
- State paths:
  - FETCH → DECODE.
  - DECODE → MEM_ADDR for LW/SW, EXECUTE for R, BRANCH for BEQ, ADDI_EXEC for ADDI, JUMP for J, TRAP for any other opcode.
  - MEM_ADDR → MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ → MEM_WB.
  - EXECUTE → ALU_WB.
  - ADDI_EXEC → ADDI_WB.
  - MEM_WB, MEM_WRITE, ALU_WB, BRANCH, ADDI_WB and JUMP → FETCH.
  - TRAP → TRAP, left only by reset.
- Outputs not listed for a state are 0:
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_b`=11.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - EXECUTE: `alu_src_a`=1, `alu_op`=10.
  - ALU_WB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10.
  - ADDI_WB: `reg_write`=1.
  - JUMP: `pc_write`=1, `pc_source`=10.
  - TRAP: `illegal_op`=1.
- Stall: FETCH, MEM_READ and MEM_WRITE hold state while `mem_ready`=0.
  - `mem_read`/`mem_write` stay asserted for the whole stall.
  - FETCH strobes `ir_write`/`pc_write` only in the cycle `mem_ready`=1.
- `retired` increments by 1 on every transition into FETCH from a terminal state. It wraps modulo 2^CNT_W and never increments from TRAP.

## Timing
- The state register updates on the rising edge of `clk`. All strobes are combinational decodes of state (plus `mem_ready` in FETCH). No output depends on `opcode` combinationally.
- Reset:
  - `rst_n`=0 immediately forces state to FETCH, `retired`=0 and `illegal_op`=0.
  - All strobes, `alu_src_b`, `alu_op` and `pc_source` read 0 while `rst_n`=0 (outputs gated by `rst_n`).
  - `state_o` reads the FETCH encoding (0).
- The first FETCH cycle is the first rising edge after `rst_n` deasserts.
- Latency with `mem_ready` held at 1, FETCH to next FETCH: R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3. Each stall cycle adds 1.
- Reset mid-instruction abandons the instruction: no retire, and no strobe after the async assert.
- `opcode` is sampled only at the DECODE and MEM_ADDR clock edges.

## Structure
- Shared package `control_pkg`:
  - opcode constants;
  - state enum, 4-bit, FETCH = 0;
  - `alu_op`, `alu_src_b` and `pc_source` encodings.
- One natural sub-module, `retire_counter`: a CNT_W counter with async active-low clear and an increment enable.
- The FSM next-state logic and the output decode stay in the top module.

## Test plan
- Reset and R-type:
  - stimulus: `rst_n` low for 3 cycles, then release with opcode=000000 and `mem_ready`=1;
  - response: all outputs are 0 during reset; states go FETCH, DECODE, EXECUTE, ALU_WB, FETCH; `reg_write`=`reg_dst`=1 only in ALU_WB; `retired`=1.
- LW with a 2-cycle stall in MEM_READ:
  - response: the LW takes 7 cycles;
  - `mem_read`=`i_or_d`=1 for 3 consecutive cycles;
  - MEM_WB follows, with `mem_to_reg`=1.
- FETCH stall:
  - stimulus: `mem_ready`=0 for 4 cycles;
  - response: `ir_write`=`pc_write`=0 throughout; exactly one cycle with both at 1 when `mem_ready` rises.
- Illegal opcode 111111 at DECODE:
  - response: TRAP reached, `illegal_op`=1 held for 20 cycles, `retired` unchanged;
  - then `rst_n` low clears `illegal_op` to 0.
- Mix BEQ, J, SW, ADDI with `MEM_HANDSHAKE`=0 and `mem_ready` tied 0:
  - response: latencies 3, 3, 4, 4 cycles; `retired`=4;
  - BEQ shows `pc_write_cond`=1 with `pc_source`=01; J shows `pc_write`=1 with `pc_source`=10.
- Counter wrap and mid-instruction reset:
  - `CNT_W`=3, run 9 R-types → `retired`=1;
  - assert `rst_n` in MEM_ADDR → `retired`=0 and state FETCH.
